// File: rtl/pllo_phase_shift_ctrl_if.sv
// Request/response channel between fabric control logic and the PLLO phase-shift controller.
interface pllo_phase_shift_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sel;
    logic       req_dir;
    logic [7:0] req_steps;
    logic       done;
    logic       aborted;

    modport master (
        output req_valid, req_sel, req_dir, req_steps,
        input  req_ready, done, aborted
    );

    modport slave (
        input  req_valid, req_sel, req_dir, req_steps,
        output req_ready, done, aborted
    );
endinterface

// File: rtl/pllo_phase_shift_ctrl.sv
// PLLO bring-up/relock sequencer and dynamic phase-shift pulse generator.
// Define PLLO_PS_POSITION_EN to add signed per-channel phase position counters (pos_b/c/d_o).
module pllo_phase_shift_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_W      = 2,
    parameter int GAP_CYC      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    pllo_phase_shift_ctrl_if.slave        req_if,
    input  logic                          pll_lock_i,
    input  logic                          relock_req_i,
    output logic                          pll_reset_o,
    output logic [1:0]                    pssel_o,
    output logic                          psdir_o,
    output logic                          pspulse_o,
    output logic                          ready_o,
    output logic                          lock_err_o
`ifdef PLLO_PS_POSITION_EN
    ,
    output logic [7:0]                    pos_b_o,
    output logic [7:0]                    pos_c_o,
    output logic [7:0]                    pos_d_o
`endif
);

    localparam int PH_MAX_A = (RST_CYCLES > SETUP_CYC) ? RST_CYCLES : SETUP_CYC;
    localparam int PH_MAX_B = (PULSE_W > GAP_CYC) ? PULSE_W : GAP_CYC;
    localparam int PH_MAX   = (PH_MAX_A > PH_MAX_B) ? PH_MAX_A : PH_MAX_B;
    localparam int PH_W     = $clog2(PH_MAX) + 1;
    localparam int ST_W     = $clog2(LOCK_STABLE) + 1;
    localparam int TO_W     = $clog2(LOCK_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        ST_RST, ST_WAIT_LOCK, ST_IDLE, ST_SETUP, ST_PULSE, ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [ST_W-1:0] stable_q, stable_d;
    logic [TO_W-1:0] timeout_q, timeout_d;
    logic [1:0]      sel_q, sel_d;
    logic            dir_q, dir_d;
    logic [7:0]      rem_q, rem_d;
    logic            relock_pend_q, relock_pend_d;
    logic            lock_err_q, lock_err_d;
    logic            noop_done_q, noop_done_d;
    logic            done_c, aborted_c, pulse_done, enter_rst, hs, busy;

    assign hs   = req_if.req_valid && (state_q == ST_IDLE);
    assign busy = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_GAP);

    always_comb begin
        state_d       = state_q;
        ph_cnt_d      = ph_cnt_q;
        stable_d      = stable_q;
        timeout_d     = timeout_q;
        sel_d         = sel_q;
        dir_d         = dir_q;
        rem_d         = rem_q;
        relock_pend_d = relock_pend_q;
        lock_err_d    = lock_err_q;
        noop_done_d   = 1'b0;
        done_c        = 1'b0;
        aborted_c     = 1'b0;
        pulse_done    = 1'b0;
        enter_rst     = 1'b0;

        case (state_q)
            ST_RST: begin
                if (ph_cnt_q == PH_W'(RST_CYCLES - 1)) begin
                    state_d   = ST_WAIT_LOCK;
                    ph_cnt_d  = '0;
                    stable_d  = '0;
                    timeout_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (relock_req_i) begin
                    enter_rst = 1'b1;
                end else if (pll_lock_i && (stable_q == ST_W'(LOCK_STABLE - 1))) begin
                    state_d    = ST_IDLE;
                    lock_err_d = 1'b0;
                end else if (timeout_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                    enter_rst  = 1'b1;
                    lock_err_d = 1'b1;
                end else begin
                    stable_d  = pll_lock_i ? stable_q + 1'b1 : '0;
                    timeout_d = timeout_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // A handshake swallowed by a lock loss or relock is reported as aborted.
                if (!pll_lock_i || relock_req_i) begin
                    enter_rst = 1'b1;
                    done_c    = hs;
                    aborted_c = hs;
                    if (!pll_lock_i) lock_err_d = 1'b1;
                end else if (hs) begin
                    sel_d = req_if.req_sel;
                    dir_d = req_if.req_dir;
                    rem_d = req_if.req_steps;
                    if ((req_if.req_sel == 2'b00) || (req_if.req_steps == 8'd0)) begin
                        noop_done_d = 1'b1;
                    end else begin
                        state_d  = ST_SETUP;
                        ph_cnt_d = '0;
                    end
                end
            end
            ST_SETUP, ST_PULSE, ST_GAP: begin
                if (!pll_lock_i) begin
                    enter_rst  = 1'b1;
                    done_c     = 1'b1;
                    aborted_c  = 1'b1;
                    lock_err_d = 1'b1;
                end else begin
                    if (relock_req_i) relock_pend_d = 1'b1;
                    if (state_q == ST_SETUP) begin
                        if (ph_cnt_q == PH_W'(SETUP_CYC - 1)) begin
                            state_d  = ST_PULSE;
                            ph_cnt_d = '0;
                        end else begin
                            ph_cnt_d = ph_cnt_q + 1'b1;
                        end
                    end else if (state_q == ST_PULSE) begin
                        if (ph_cnt_q == PH_W'(PULSE_W - 1)) begin
                            state_d    = ST_GAP;
                            ph_cnt_d   = '0;
                            pulse_done = 1'b1;
                        end else begin
                            ph_cnt_d = ph_cnt_q + 1'b1;
                        end
                    end else begin
                        if (ph_cnt_q == PH_W'(GAP_CYC - 1)) begin
                            ph_cnt_d = '0;
                            if (rem_q == 8'd0) begin
                                done_c = 1'b1;
                                if (relock_pend_q || relock_req_i) enter_rst = 1'b1;
                                else                               state_d   = ST_IDLE;
                            end else begin
                                state_d = ST_PULSE;
                            end
                        end else begin
                            ph_cnt_d = ph_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: enter_rst = 1'b1;
        endcase

        if (pulse_done) rem_d = rem_q - 1'b1;

        if (enter_rst) begin
            state_d       = ST_RST;
            ph_cnt_d      = '0;
            relock_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_RST;
            ph_cnt_q      <= '0;
            stable_q      <= '0;
            timeout_q     <= '0;
            sel_q         <= 2'b00;
            dir_q         <= 1'b0;
            rem_q         <= 8'd0;
            relock_pend_q <= 1'b0;
            lock_err_q    <= 1'b0;
            noop_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ph_cnt_q      <= ph_cnt_d;
            stable_q      <= stable_d;
            timeout_q     <= timeout_d;
            sel_q         <= sel_d;
            dir_q         <= dir_d;
            rem_q         <= rem_d;
            relock_pend_q <= relock_pend_d;
            lock_err_q    <= lock_err_d;
            noop_done_q   <= noop_done_d;
        end
    end

    assign pll_reset_o      = (state_q == ST_RST);
    assign pspulse_o        = (state_q == ST_PULSE);
    assign ready_o          = (state_q == ST_IDLE);
    assign pssel_o          = busy ? sel_q : 2'b00;
    assign psdir_o          = busy & dir_q;
    assign lock_err_o       = lock_err_q;
    assign req_if.req_ready = (state_q == ST_IDLE);
    assign req_if.done      = done_c | noop_done_q;
    assign req_if.aborted   = aborted_c;

`ifdef PLLO_PS_POSITION_EN
    logic [7:0] pos_q [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pos
            always_ff @(posedge clk_i) begin
                if (rst_i || enter_rst) begin
                    pos_q[gi] <= 8'd0;
                end else if (pulse_done && (sel_q == 2'(gi + 1))) begin
                    pos_q[gi] <= pos_q[gi] + (dir_q ? 8'd1 : 8'hFF);
                end
            end
        end
    endgenerate

    assign pos_b_o = pos_q[0];
    assign pos_c_o = pos_q[1];
    assign pos_d_o = pos_q[2];
`endif

endmodule
